// File: rtl/sparse_tok_pkg.sv
// rtl/sparse_tok_pkg.sv - sparse token definitions shared by the sparse stream stages
package sparse_tok_pkg;

   localparam int TOK_W = 17;
   localparam logic [TOK_W-1:0] DONE_TOKEN = 17'h10100;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } joiner_state_t;

   function automatic logic is_ctrl(input logic [TOK_W-1:0] tok);
      return tok[16];
   endfunction

   function automatic logic is_done(input logic [TOK_W-1:0] tok);
      return tok == DONE_TOKEN;
   endfunction

   function automatic logic is_stop(input logic [TOK_W-1:0] tok);
      return tok[16] && (tok[9:8] == 2'b00);
   endfunction

   // Two heads may be joined if both carry data, or both carry the same control token.
   function automatic logic tok_compatible(input logic [TOK_W-1:0] a, input logic [TOK_W-1:0] b);
      return (!a[16] && !b[16]) || (a[16] && b[16] && (a == b));
   endfunction

endpackage

// File: rtl/fiber_stream_joiner_if.sv
// rtl/fiber_stream_joiner_if.sv - coord/pos input streams and joined output stream
interface fiber_stream_joiner_if;
   import sparse_tok_pkg::*;

   logic [TOK_W-1:0]   coord_in;
   logic               coord_in_valid;
   logic               coord_in_ready;
   logic [TOK_W-1:0]   pos_in;
   logic               pos_in_valid;
   logic               pos_in_ready;
   logic [2*TOK_W-1:0] joined_out;
   logic               joined_valid;
   logic               joined_ready;

   modport master (
      output coord_in, coord_in_valid, pos_in, pos_in_valid, joined_ready,
      input  coord_in_ready, pos_in_ready, joined_out, joined_valid
   );

   modport slave (
      input  coord_in, coord_in_valid, pos_in, pos_in_valid, joined_ready,
      output coord_in_ready, pos_in_ready, joined_out, joined_valid
   );

endinterface

// File: rtl/fiber_stream_joiner_stream_fifo.sv
// rtl/fiber_stream_joiner_stream_fifo.sv - registered-storage sync FIFO with full/empty flags
module stream_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/fiber_stream_joiner.sv
// rtl/fiber_stream_joiner.sv - joins coord/pos token streams into pairs, checks control
// alignment and reports per-tile data pair counts on DONE
module fiber_stream_joiner
   import sparse_tok_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_en,
   input  logic                 flush,
   fiber_stream_joiner_if.slave bus,
   output logic                 done_pulse,
   output logic [CNT_W-1:0]     tile_len,
   output logic                 mismatch_err
);

   joiner_state_t    state;
   joiner_state_t    state_nxt;
   logic [TOK_W-1:0] c_head;
   logic [TOK_W-1:0] p_head;
   logic             c_full;
   logic             c_empty;
   logic             p_full;
   logic             p_empty;
   logic             c_push;
   logic             p_push;
   logic             pop;
   logic             both_present;
   logic             heads_ok;
   logic             halted;
   logic [CNT_W-1:0] pair_cnt;

   stream_fifo #(.WIDTH(TOK_W), .DEPTH(DEPTH)) u_coord_fifo (
      .clk(clk), .rst(rst), .flush(flush),
      .push(c_push), .push_data(bus.coord_in), .pop(pop),
      .head(c_head), .full(c_full), .empty(c_empty)
   );

   stream_fifo #(.WIDTH(TOK_W), .DEPTH(DEPTH)) u_pos_fifo (
      .clk(clk), .rst(rst), .flush(flush),
      .push(p_push), .push_data(bus.pos_in), .pop(pop),
      .head(p_head), .full(p_full), .empty(p_empty)
   );

   assign both_present = !c_empty && !p_empty;
   assign heads_ok     = tok_compatible(c_head, p_head);
   // Inputs close as soon as a disagreement is visible, not one cycle later in HALT.
   assign halted       = (state == HALT) || (both_present && !heads_ok);

   assign bus.coord_in_ready = clk_en && !c_full && !halted;
   assign bus.pos_in_ready   = clk_en && !p_full && !halted;
   assign c_push             = bus.coord_in_valid && bus.coord_in_ready;
   assign p_push             = bus.pos_in_valid && bus.pos_in_ready;

   assign bus.joined_valid = clk_en && both_present && heads_ok && (state != HALT);
   assign bus.joined_out   = {c_head, p_head};
   assign pop              = bus.joined_valid && bus.joined_ready;
   assign done_pulse       = pop && is_done(c_head);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (c_push || p_push) state_nxt = RUN;
         RUN:     if (done_pulse && !(c_push || p_push)) state_nxt = IDLE;
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
      if (clk_en && both_present && !heads_ok) state_nxt = HALT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         pair_cnt     <= '0;
         tile_len     <= '0;
         mismatch_err <= 1'b0;
      end else if (flush) begin
         state        <= IDLE;
         pair_cnt     <= '0;
         tile_len     <= '0;
         mismatch_err <= 1'b0;
      end else if (clk_en) begin
         state <= state_nxt;
         if (state_nxt == HALT) mismatch_err <= 1'b1;
         if (done_pulse) begin
            tile_len <= pair_cnt;
            pair_cnt <= '0;
         end else if (pop && !is_ctrl(c_head) && (pair_cnt != '1)) begin
            pair_cnt <= pair_cnt + 1'b1;
         end
      end
   end

endmodule
